// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Combinational only: no clocked logic and no flow control here.
// Holds the drop-counter width and the select-width calculation.
package demux_pkg;

    localparam int DROP_W = 8;

    // Binary select width for n channels; never narrower than one bit.
    function automatic int sel_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output holding register (valid bit plus data) for a single channel.
// Latency: 1 cycle from load to valid. Backpressure: holds valid/data until ready.
// A load on the same edge as a drain keeps valid high and replaces the data.
module demux_out_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            // Data is left in place so idle channels keep their last value.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to NUM_CH outputs by in_sel; out-of-range beats are counted and dropped.
// Latency: 1 cycle. Backpressure: in_ready drops only when the selected channel is full and stalled.
// STREAM_DEMUX_ONEHOT_EN: in_sel becomes NUM_CH-bit one-hot; non-one-hot values count as out of range.
module stream_demux
    import demux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4,
`ifdef STREAM_DEMUX_ONEHOT_EN
    localparam int SEL_W = NUM_CH
`else
    localparam int SEL_W = sel_w(NUM_CH)
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [DROP_W-1:0]        drop_cnt
);

    logic [NUM_CH-1:0] sel_hot;
    logic              sel_ok;
    logic              accept;
    logic              drop;
    logic [NUM_CH-1:0] load;

`ifdef STREAM_DEMUX_ONEHOT_EN
    always_comb begin
        sel_hot = in_sel;
        sel_ok  = (in_sel != '0) && ((in_sel & (in_sel - SEL_W'(1))) == '0);
    end
`else
    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_hot[k] = (in_sel == SEL_W'(k));
        end
        sel_ok = |sel_hot;
    end
`endif

    // Out-of-range beats are always accepted so they can never stall the stream.
    assign in_ready = enable & (~sel_ok | (|(sel_hot & (~out_valid | out_ready))));
    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~sel_ok;
    assign load     = sel_hot & {NUM_CH{accept & sel_ok}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        demux_out_reg #(
            .DATA_W(DATA_W)
        ) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed plus random checks of stream_demux against a per-channel queue scoreboard.
// A second NUM_CH=3 instance exercises out-of-range drops and counter saturation.
module tb_stream_demux;

    localparam int N  = 4;
    localparam int W  = 4;
`ifdef STREAM_DEMUX_ONEHOT_EN
    localparam int SW  = 4;
    localparam int SW3 = 3;
`else
    localparam int SW  = 2;
    localparam int SW3 = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [SW-1:0]  in_sel = '0;
    logic [W-1:0]   in_data = '0;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready = '1;
    logic [N*W-1:0] out_data;
    logic [7:0]     drop_cnt;

    logic           in_valid3 = 1'b0;
    logic           in_ready3;
    logic [SW3-1:0] in_sel3 = '0;
    logic [W-1:0]   in_data3 = '0;
    logic [2:0]     out_valid3;
    logic [2:0]     out_ready3 = '1;
    logic [3*W-1:0] out_data3;
    logic [7:0]     drop_cnt3;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] q[N][$];
    logic [W-1:0] last_dat[N];
    int           exp_drop = 0;

    always #5 clk = ~clk;

    stream_demux #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drop_cnt(drop_cnt)
    );

    stream_demux #(.NUM_CH(3), .DATA_W(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_sel(in_sel3), .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .drop_cnt(drop_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [SW-1:0] enc(input int k);
`ifdef STREAM_DEMUX_ONEHOT_EN
        return SW'(1) << k;
`else
        return SW'(k);
`endif
    endfunction

    function automatic bit sel_valid(input logic [SW-1:0] s);
`ifdef STREAM_DEMUX_ONEHOT_EN
        return $countones(s) == 1;
`else
        return int'(s) < N;
`endif
    endfunction

    function automatic int sel_idx(input logic [SW-1:0] s);
`ifdef STREAM_DEMUX_ONEHOT_EN
        int r;
        r = 0;
        for (int i = SW - 1; i >= 0; i--) if (s[i]) r = i;
        return r;
`else
        return int'(s);
`endif
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic tick();
        bit ok;
        int idx;
        bit exp_rdy;
        logic [W-1:0] exp_d;
        #3;
        ok      = sel_valid(in_sel);
        idx     = ok ? sel_idx(in_sel) : 0;
        exp_rdy = enable && (!ok || q[idx].size() == 0 || out_ready[idx]);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
            exp_d = (q[k].size() != 0) ? q[k][0] : last_dat[k];
            chk($sformatf("out_data%0d", k), 32'(out_data[k*W +: W]), 32'(exp_d));
        end
        for (int k = 0; k < N; k++) begin
            if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
        end
        if (in_valid && exp_rdy) begin
            if (ok) begin
                q[idx].push_back(in_data);
                last_dat[idx] = in_data;
            end else begin
                exp_drop = sat_inc(exp_drop);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input logic [W-1:0] d);
        in_valid = v;
        in_sel   = enc(ch);
        in_data  = d;
        tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) last_dat[k] = '0;

        // Reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_valid3", 32'(out_valid3), 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // One beat to each channel back to back, all sinks ready
        for (int s = 0; s < N; s++) drive(1'b1, s, 4'b1010);
        drive(1'b0, 0, 4'b0000);
        drive(1'b0, 0, 4'b0000);

        // Channel 2 stalled: second beat waits, channel 0 keeps flowing
        out_ready[2] = 1'b0;
        drive(1'b1, 2, 4'b1111);
        drive(1'b1, 2, 4'b0011);
        drive(1'b1, 0, 4'b0101);
        out_ready[2] = 1'b1;
        drive(1'b1, 2, 4'b0011);
        drive(1'b0, 0, 4'b0000);
        drive(1'b0, 0, 4'b0000);

        // Enable low: held beat drains, nothing new accepted
        out_ready[1] = 1'b0;
        drive(1'b1, 1, 4'b1100);
        drive(1'b0, 1, 4'b0000);
        enable = 1'b0;
        out_ready[1] = 1'b1;
        drive(1'b1, 1, 4'b0110);
        drive(1'b1, 0, 4'b0001);
        enable = 1'b1;
        drive(1'b0, 0, 4'b0000);

`ifdef STREAM_DEMUX_ONEHOT_EN
        in_valid = 1'b1; in_sel = 4'b0100; in_data = 4'b1001; tick();
        in_valid = 1'b1; in_sel = 4'b0110; in_data = 4'b0111; tick();
        in_valid = 1'b1; in_sel = 4'b0000; in_data = 4'b0111; tick();
        drive(1'b0, 0, 4'b0000);
`endif

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            out_ready = N'($urandom_range(0, (1 << N) - 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = W'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 3) == 0) in_sel = SW'($urandom);
            else                           in_sel = enc($urandom_range(0, N - 1));
            tick();
        end
        out_ready = '1;
        drive(1'b0, 0, 4'b0000);
        drive(1'b0, 0, 4'b0000);

        // Out-of-range select on the 3-channel instance: drop and saturate
        in_valid3 = 1'b1;
        in_sel3   = '1;
        in_data3  = 4'b0101;
        for (int i = 0; i < 300; i++) begin
            #3;
            if (i % 50 == 0) chk("in_ready3", 32'(in_ready3), 32'h1);
            @(posedge clk);
            #1;
            chk("out_valid3", 32'(out_valid3), 32'h0);
            if (i < 3 || i >= 252) chk("drop_cnt3", 32'(drop_cnt3), 32'((i + 1 > 255) ? 255 : i + 1));
        end
        in_valid3 = 1'b0;

        // Asynchronous reset mid-stream with channel 3 holding a beat
        out_ready[3] = 1'b0;
        drive(1'b1, 3, 4'b0111);
        drive(1'b0, 0, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_drop", 32'(drop_cnt), 32'h0);
        chk("arst_drop3", 32'(drop_cnt3), 32'h0);
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            last_dat[k] = '0;
        end
        exp_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = '1;
        // First edge after reset release must already accept
        drive(1'b1, 1, 4'b1110);
        drive(1'b0, 0, 4'b0000);
        drive(1'b0, 0, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
